// File: rtl/demux_rr_dispatcher.sv
// Round-robin feeder for a 1-to-4 demux: one-entry output register, lane skipping,
// and per-lane delivered-word counters.
module demux_rr_dispatcher #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    input  logic [3:0]    lane_en,
    input  logic [3:0]    lane_ready,
    output logic [1:0]    select,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt2,
    output logic [CW-1:0] cnt3
);

    logic [1:0]    r_ptr;
    logic [1:0]    r_select;
    logic          r_out_valid;
    logic [N-1:0]  r_out_data;
    logic [CW-1:0] r_cnt [4];

    logic          w_take;
    logic          w_free;
    logic          w_any_en;
    logic          w_acc;
    logic [1:0]    w_cand;

    assign w_take   = r_out_valid & lane_ready[r_select];
    assign w_free   = ~r_out_valid | w_take;
    assign w_any_en = |lane_en;
    assign in_ready = w_free & w_any_en;
    assign w_acc    = in_valid & in_ready;

    // Search from the farthest offset back to ptr so the nearest enabled lane wins.
    always_comb begin
        logic [1:0] idx;
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        w_cand = r_ptr;
        idx    = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = r_ptr + 2'(i);
            if (lane_en[idx]) begin
                w_cand = idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr       <= 2'd0;
            r_select    <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_acc) begin
            r_out_valid <= 1'b1;
            r_select    <= w_cand;
            r_out_data  <= in_data;
            r_ptr       <= w_cand + 2'd1;
        end else if (w_take) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end
    end

    // NOTE: the counter array is architectural state visible on ports, so every entry is reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_cnt[k] <= '0;
            end
        end else if (w_take) begin
            r_cnt[r_select] <= r_cnt[r_select] + CW'(1);
        end
    end

    assign select    = r_select;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign cnt0      = r_cnt[0];
    assign cnt1      = r_cnt[1];
    assign cnt2      = r_cnt[2];
    assign cnt3      = r_cnt[3];

endmodule
